// File: rtl/traffic_pkg.sv
// ============================================================================
// Module   : traffic_pkg
// Brief    : Shared constants and enums for the traffic-light light filter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    localparam int ADC_W            = 10;

    localparam int DEF_SAMPLE_DIV   = 100000;
    localparam int DEF_AVG_LOG2     = 3;
    localparam int DEF_NIGHT_TH     = 300;
    localparam int DEF_DAY_TH       = 400;
    localparam int DEF_HOLD_SAMPLES = 4;

    typedef enum logic [0:0] {
        MODE_DAY   = 1'b0,
        MODE_NIGHT = 1'b1
    } light_mode_t;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } filt_state_t;

endpackage

`default_nettype wire

// File: rtl/light_level_filter_moving_avg.sv
// ============================================================================
// Module   : moving_avg
// Brief    : Circular-buffer moving average over 2^AVG_LOG2 ticked samples.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module moving_avg
    import traffic_pkg::*;
#(
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADC_W-1:0] sample_i,
    input  logic             tick_i,
    output logic [ADC_W-1:0] avg_o,
    output logic [ADC_W-1:0] avg_next_o,
    output logic             full_o
);

    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = ADC_W + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;

    logic [ADC_W-1:0]    mem_q [DEPTH];
    logic [SUM_W-1:0]    sum_q;
    logic [SUM_W-1:0]    sum_d;
    logic [AVG_LOG2-1:0] wp_q;
    logic [FILL_W-1:0]   fill_q;
    logic                full_q;
    logic [ADC_W-1:0]    avg_q;

    // The oldest entry is always part of sum_q, so the subtraction cannot underflow.
    always_comb begin
        sum_d      = sum_q + SUM_W'(sample_i) - SUM_W'(mem_q[wp_q]);
        avg_next_o = ADC_W'(sum_d >> AVG_LOG2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            sum_q  <= '0;
            wp_q   <= '0;
            fill_q <= '0;
            full_q <= 1'b0;
            avg_q  <= '0;
        end else if (tick_i) begin
            mem_q[wp_q] <= sample_i;
            sum_q       <= sum_d;
            wp_q        <= wp_q + 1'b1;
            avg_q       <= avg_next_o;
            if (!full_q) begin
                fill_q <= fill_q + 1'b1;
                if (fill_q == FILL_W'(DEPTH - 1)) begin
                    full_q <= 1'b1;
                end
            end
        end
    end

    assign avg_o  = avg_q;
    assign full_o = full_q;

endmodule

`default_nettype wire

// File: rtl/light_level_filter.sv
// ============================================================================
// Module   : light_level_filter
// Brief    : Samples the ADC light level, averages it and debounces day/night.
//            Optional LIGHT_FILTER_OVERRIDE_EN adds force_night/force_day.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module light_level_filter
    import traffic_pkg::*;
#(
    parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
    parameter int AVG_LOG2     = DEF_AVG_LOG2,
    parameter int NIGHT_TH     = DEF_NIGHT_TH,
    parameter int DAY_TH       = DEF_DAY_TH,
    parameter int HOLD_SAMPLES = DEF_HOLD_SAMPLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADC_W-1:0] light_sensor,
`ifdef LIGHT_FILTER_OVERRIDE_EN
    input  logic             force_night,
    input  logic             force_day,
`endif
    output logic [ADC_W-1:0] avg_level,
    output logic             avg_valid,
    output logic             is_night,
    output logic             mode_change,
    output logic             sample_tick
);

    localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int HOLD_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES + 1) : 1;

    logic [ADC_W-1:0]  s1_q;
    logic [ADC_W-1:0]  s2_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              tick;

    filt_state_t       state_q;
    filt_state_t       state_d;
    light_mode_t       mode_q;
    light_mode_t       mode_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic [HOLD_W-1:0] hold_inc;
    logic              mc_q;
    logic              mc_d;
    logic              qualify;

    logic [ADC_W-1:0]  avg_cur;
    logic [ADC_W-1:0]  avg_next;
    logic              full;

    assign tick  = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    moving_avg #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk        (clk),
        .rst        (rst),
        .sample_i   (s2_q),
        .tick_i     (tick),
        .avg_o      (avg_cur),
        .avg_next_o (avg_next),
        .full_o     (full)
    );

    // FILL->RUN lags full by one cycle; harmless since ticks are >=2 cycles apart.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        hold_d   = hold_q;
        mc_d     = 1'b0;
        hold_inc = hold_q + HOLD_W'(1);
        qualify  = (mode_q == MODE_DAY) ? (avg_next < ADC_W'(NIGHT_TH))
                                        : (avg_next > ADC_W'(DAY_TH));
        case (state_q)
            FILL: begin
                if (full) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    if (!qualify) begin
                        hold_d = '0;
                    end else if (hold_inc == HOLD_W'(HOLD_SAMPLES)) begin
                        mode_d = (mode_q == MODE_DAY) ? MODE_NIGHT : MODE_DAY;
                        mc_d   = 1'b1;
                        hold_d = '0;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
            end
            default: state_d = FILL;
        endcase
`ifdef LIGHT_FILTER_OVERRIDE_EN
        if (force_night || force_day) begin
            mode_d = force_night ? MODE_NIGHT : MODE_DAY;
            hold_d = '0;
            mc_d   = (mode_d != mode_q);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            cnt_q   <= '0;
            state_q <= FILL;
            mode_q  <= MODE_DAY;
            hold_q  <= '0;
            mc_q    <= 1'b0;
        end else begin
            s1_q    <= light_sensor;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            mode_q  <= mode_d;
            hold_q  <= hold_d;
            mc_q    <= mc_d;
        end
    end

    assign avg_level   = avg_cur;
    assign avg_valid   = full;
    assign is_night    = (mode_q == MODE_NIGHT);
    assign mode_change = mc_q;
    assign sample_tick = tick;

endmodule

`default_nettype wire
